aes_key_sched_ctrl: RTL and testbench
=====================================

Name: aes_key_sched_ctrl

Overview:
- Sequencer for the single-round AES-128 key-expansion datapath.
- Accepts a 128-bit cipher key, runs the round function 10 times (one round per cycle) and stores all 11 round keys in an internal register file.
- Serves the round keys one per handshake to the round engine, in encrypt order (0..10) or decrypt order (10..0).
- Supports replaying a stored schedule for further blocks under the same key without re-expansion.

Parameters:
- NR, 10, number of expansion rounds; register file holds NR+1 keys. Only 10 (AES-128) is supported.
- KW, 128, round-key width in bits; MSB-first [0:KW-1] ordering.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- key_in  in  [0:127]  cipher key (round-0 key).
- key_valid  in  1  key_in valid.
- key_ready  out  1  controller can accept a key; high only in IDLE.
- dir  in  1  serve order, sampled at accept or replay: 0 = 0..10, 1 = 10..0.
- replay_req  in  1  re-serve the stored schedule (IDLE only).
- abort  in  1  return to IDLE and invalidate the schedule.
- sched_done  out  1  one-cycle pulse when expansion completes.
- sched_valid  out  1  a complete schedule is stored.
- rk_out  out  [0:127]  current round key; all zeros when rk_valid=0.
- rk_idx  out  [0:3]  round number of rk_out.
- rk_valid  out  1  rk_out/rk_idx valid.
- rk_next  in  1  consumer takes the current key (effective when rk_valid=1).

Behaviour:
- States: IDLE, EXPAND, SERVE.
- Reset values: state IDLE, key_ready=1, sched_valid=0, sched_done=0, rk_valid=0, rk_out=0, rk_idx=0.
- Key register file is not reset. rk_out is gated to zero while rk_valid=0.
- IDLE:
  - key_valid=1 at edge E0: slot[0]<=key_in, round_cnt<=1, dir latched, sched_valid<=0, go to EXPAND.
  - replay_req=1 with sched_valid=1: dir latched, ptr<=(dir?10:0), go to SERVE.
  - replay_req with sched_valid=0 is ignored.
  - key_valid and replay_req in the same cycle: key_valid wins.
- EXPAND:
  - Each edge: slot[round_cnt]<=round_fn(round_cnt, slot[round_cnt-1]), then round_cnt++.
  - Slots 1..10 are written at edges E1..E10.
  - At E10: go to SERVE, sched_valid<=1, ptr<=(dir?10:0), sched_done=1 for the single cycle after E10.
  - First rk_valid cycle follows E10, so latency from accept to first key is 11 cycles.
  - key_valid, replay_req and rk_next are ignored.
- SERVE:
  - rk_valid=1, rk_out=slot[ptr], rk_idx=ptr, with no bubble between keys.
  - rk_next=1: ptr advances (dir=0: +1, dir=1: -1).
  - rk_next on the last key (ptr=10 for dir=0, ptr=0 for dir=1): go to IDLE; rk_valid drops the next cycle; sched_valid stays 1.
  - rk_next held continuously gives 11 keys in 11 consecutive cycles.
  - key_valid is ignored (key_ready=0).
- abort has priority over all other inputs in every state:
  - next edge: state IDLE, sched_valid<=0, rk_valid<=0.
  - abort during EXPAND discards partial results; sched_done does not fire.
- rst mid-operation behaves identically to abort and also clears the outputs to their reset values.
- round_fn:
  - byte-rotate word 3, then S-box each byte, then XOR rcon(round_cnt) into byte 0.
  - w0'=w0^t, w1'=w1^w0', w2'=w2^w1', w3'=w3^w2'.
  - rcon sequence: 01,02,04,08,10,20,40,80,1b,36.
- Widths: round_cnt and ptr are 4 bits and never leave the range 0..10.

Decomposition:
- Package aes_pkg holds:
  - localparams NR=10, KW=128.
  - state encoding (IDLE=2'd0, EXPAND=2'd1, SERVE=2'd2).
  - rcon and sbox functions, shared with the cipher datapath.
- Sub-module aes_key_round: purely combinational one-round expansion with ports round_num[0:3], keyin[0:127], keyout[0:127]. Instantiated once and fed from slot[round_cnt-1].

Test Plan:
- FIPS-197 key 000102030405060708090a0b0c0d0e0f, dir=0, rk_next held high:
  - sched_done 11 cycles after accept.
  - idx1 = d6aa74fdd2af72fadaa678f1d6ab76fe.
  - idx10 = 13111d7fe3944a17f307a78b4d2b30c5.
  - 11 consecutive valid cycles, then key_ready=1.
- Key 2b7e151628aed2a6abf7158809cf4f3c, dir=1:
  - first rk_out = d014f9a8c9ee2589e13f0cc8b6630ca6 with rk_idx=10.
  - last rk_out = 2b7e1516...4f3c with rk_idx=0.
- Stall in SERVE with rk_next toggled 1,0,0,1: rk_out and rk_idx hold during the 0 cycles, and no key is skipped or duplicated.
- After a completed schedule, replay_req with dir=0: SERVE is entered on the next cycle without sched_done, and idx0..10 match the first run.
- abort at EXPAND cycle 5: sched_valid=0, no sched_done, key_ready=1 on the next cycle, and a subsequent replay_req is ignored.
- key_valid and replay_req asserted together in IDLE: a new expansion starts. Also, rst asserted during SERVE clears all outputs to their reset values on the next cycle.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES definitions for the key-schedule controller and cipher datapath:
// sizes, controller states and the S-box / round-constant helpers.
package aes_pkg;

  localparam int NR = 10;
  localparam int KW = 128;
  localparam logic [0:3] LAST_RND = 4'd10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    SERVE  = 2'd2
  } state_t;

  // Forward S-box, entry b lives at bits [8*b +: 8] (MSB-first).
  localparam logic [0:2047] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TBL[{b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [0:3] rnd);
    case (rnd)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/aes_key_round.sv
// One AES-128 key-expansion round: derives round key N from round key N-1.
module aes_key_round
  import aes_pkg::*;
(
  input  logic [0:3]    round_num,
  input  logic [0:KW-1] keyin,
  output logic [0:KW-1] keyout
);

  logic [0:31] w0, w1, w2, w3;
  logic [0:31] t;
  logic [0:31] n0, n1, n2, n3;

  assign w0 = keyin[0:31];
  assign w1 = keyin[32:63];
  assign w2 = keyin[64:95];
  assign w3 = keyin[96:127];

  // RotWord then SubWord on w3, round constant folded into the leading byte
  assign t = {sbox(w3[8:15]) ^ rcon(round_num), sbox(w3[16:23]),
              sbox(w3[24:31]), sbox(w3[0:7])};

  assign n0 = w0 ^ t;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  assign keyout = {n0, n1, n2, n3};

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// AES-128 key-schedule sequencer: expands a cipher key into 11 stored round
// keys and serves them one per handshake in encrypt or decrypt order.
module aes_key_sched_ctrl
  import aes_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic [0:KW-1] key_in,
  input  logic          key_valid,
  output logic          key_ready,
  input  logic          dir,
  input  logic          replay_req,
  input  logic          abort,
  output logic          sched_done,
  output logic          sched_valid,
  output logic [0:KW-1] rk_out,
  output logic [0:3]    rk_idx,
  output logic          rk_valid,
  input  logic          rk_next
);

  state_t state, state_nxt;

  logic [0:KW-1] slot [0:NR];
  logic [0:3]    round_cnt;
  logic [0:3]    ptr;
  logic          dir_q;
  logic [0:KW-1] next_key;

  logic load_key, expand_step, expand_last, serve_start, advance;
  logic [0:3] last_ptr;

  aes_key_round u_round (
    .round_num (round_cnt),
    .keyin     (slot[round_cnt - 4'd1]),
    .keyout    (next_key)
  );

  assign last_ptr = dir_q ? 4'd0 : LAST_RND;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    load_key    = 1'b0;
    expand_step = 1'b0;
    expand_last = 1'b0;
    serve_start = 1'b0;
    advance     = 1'b0;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (key_valid) begin
            load_key  = 1'b1;
            state_nxt = EXPAND;
          end else if (replay_req && sched_valid) begin
            serve_start = 1'b1;
            state_nxt   = SERVE;
          end
        end
        EXPAND: begin
          expand_step = 1'b1;
          if (round_cnt == LAST_RND) begin
            expand_last = 1'b1;
            state_nxt   = SERVE;
          end
        end
        SERVE: begin
          if (rk_next) begin
            if (ptr == last_ptr) state_nxt = IDLE;
            else                 advance   = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      round_cnt   <= '0;
      ptr         <= '0;
      dir_q       <= 1'b0;
      sched_valid <= 1'b0;
      sched_done  <= 1'b0;
    end else begin
      sched_done <= expand_last;
      if (abort) sched_valid <= 1'b0;
      if (load_key) begin
        round_cnt   <= 4'd1;
        dir_q       <= dir;
        sched_valid <= 1'b0;
      end
      if (expand_step) round_cnt <= expand_last ? 4'd0 : round_cnt + 4'd1;
      if (expand_last) begin
        sched_valid <= 1'b1;
        ptr         <= dir_q ? LAST_RND : 4'd0;
      end
      if (serve_start) begin
        dir_q <= dir;
        ptr   <= dir ? LAST_RND : 4'd0;
      end
      if (advance) ptr <= dir_q ? ptr - 4'd1 : ptr + 4'd1;
    end
  end

  // Key storage carries no reset; contents only matter once sched_valid is set
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (load_key)    slot[0]         <= key_in;
      if (expand_step) slot[round_cnt] <= next_key;
    end
  end

  assign key_ready = (state == IDLE);
  assign rk_valid  = (state == SERVE);
  assign rk_out    = rk_valid ? slot[ptr] : '0;
  assign rk_idx    = rk_valid ? ptr : '0;

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Directed bench for aes_key_sched_ctrl: a transaction-level key-schedule model
// checked every cycle, plus FIPS-197 literal round keys.
module tb_aes_key_sched_ctrl;

  logic         clk;
  logic         rst;
  logic [0:127] key_in;
  logic         key_valid;
  logic         key_ready;
  logic         dir;
  logic         replay_req;
  logic         abort;
  logic         sched_done;
  logic         sched_valid;
  logic [0:127] rk_out;
  logic [0:3]   rk_idx;
  logic         rk_valid;
  logic         rk_next;

  aes_key_sched_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .key_in      (key_in),
    .key_valid   (key_valid),
    .key_ready   (key_ready),
    .dir         (dir),
    .replay_req  (replay_req),
    .abort       (abort),
    .sched_done  (sched_done),
    .sched_valid (sched_valid),
    .rk_out      (rk_out),
    .rk_idx      (rk_idx),
    .rk_valid    (rk_valid),
    .rk_next     (rk_next)
  );

  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  int n_checks = 0;
  int n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // S-box built from GF(2^8) inversion plus the affine map
  logic [7:0] sb [256];

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int x = 1; x < 256; x++)
        if (gmul(8'(a), 8'(x)) == 8'h01) inv = 8'(x);
      sb[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  // Word-oriented key expansion, returning round key r
  function automatic logic [127:0] round_key(input logic [127:0] k, input int r);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ t;
    end
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  // Model: 0 idle, 1 expanding, 2 serving; m_pos counts keys already handed out
  int           m_mode = 0;
  int           m_left = 0;
  int           m_pos  = 0;
  bit           m_dir  = 0;
  bit           m_have = 0;
  bit           m_done = 0;
  bit           model_live = 0;
  logic [127:0] m_keys [0:10];

  always @(posedge clk) begin
    model_live = 1;
    m_done = 0;
    if (rst) begin
      m_mode = 0; m_have = 0; m_pos = 0;
    end else if (abort) begin
      m_mode = 0; m_have = 0;
    end else begin
      case (m_mode)
        0: begin
          if (key_valid) begin
            for (int r = 0; r <= 10; r++) m_keys[r] = round_key(key_in, r);
            m_mode = 1; m_left = 10; m_dir = dir; m_have = 0;
          end else if (replay_req && m_have) begin
            m_mode = 2; m_pos = 0; m_dir = dir;
          end
        end
        1: begin
          m_left--;
          if (m_left == 0) begin
            m_mode = 2; m_pos = 0; m_have = 1; m_done = 1;
          end
        end
        default: begin
          if (rk_next) begin
            if (m_pos == 10) m_mode = 0;
            else             m_pos++;
          end
        end
      endcase
    end
  end

  always @(negedge clk) begin
    int ei;
    if (model_live) begin
      ei = m_dir ? 10 - m_pos : m_pos;
      check("cyc key_ready", key_ready, m_mode == 0);
      check("cyc sched_valid", sched_valid, m_have);
      check("cyc sched_done", sched_done, m_done);
      check("cyc rk_valid", rk_valid, m_mode == 2);
      check("cyc rk_out", rk_out, (m_mode == 2) ? m_keys[ei] : 128'h0);
      if (m_mode == 2) check("cyc rk_idx", rk_idx, ei);
    end
  end

  task automatic wait_done(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      key_valid  = 1'b0;
      replay_req = 1'b0;
    end while (!sched_done && cyc < 40);
    check("sched_done seen", sched_done, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " key_ready"}, key_ready, 1);
    check({tag, " sched_valid"}, sched_valid, 0);
    check({tag, " sched_done"}, sched_done, 0);
    check({tag, " rk_valid"}, rk_valid, 0);
    check({tag, " rk_out"}, rk_out, 0);
    check({tag, " rk_idx"}, rk_idx, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int cyc, err, done_seen;
    int taken[$];
    bit pat[4] = '{1, 0, 0, 1};
    logic [3:0]   prev_idx;
    logic [127:0] prev_out, last_out;
    bit prev_next, have_prev;

    build_sbox();
    rst = 1; key_in = '0; key_valid = 0; dir = 0; replay_req = 0; abort = 0; rk_next = 0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 0;
    @(negedge clk);

    // Encrypt order, consumer always ready
    rk_next = 1; dir = 0; key_in = K1; key_valid = 1;
    wait_done(cyc);
    check("t1 latency", cyc, 11);
    for (int i = 0; i < 11; i++) begin
      check("t1 rk_valid", rk_valid, 1);
      check("t1 rk_idx", rk_idx, i);
      if (i == 1)  check("t1 idx1 literal", rk_out, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe);
      if (i == 10) check("t1 idx10 literal", rk_out, 128'h13111d7fe3944a17f307a78b4d2b30c5);
      @(negedge clk);
    end
    check("t1 end key_ready", key_ready, 1);
    check("t1 end rk_valid", rk_valid, 0);

    // Replay stored schedule
    dir = 0; replay_req = 1;
    @(negedge clk);
    replay_req = 0;
    check("replay rk_valid", rk_valid, 1);
    check("replay no done", sched_done, 0);
    for (int i = 0; i < 11; i++) begin
      check("replay rk_idx", rk_idx, i);
      check("replay rk_out", rk_out, round_key(K1, i));
      @(negedge clk);
    end
    check("replay end key_ready", key_ready, 1);

    // Decrypt order with stalls
    rk_next = 0; dir = 1; key_in = K2; key_valid = 1;
    wait_done(cyc);
    check("t2 first literal", rk_out, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    check("t2 first idx", rk_idx, 10);
    have_prev = 0; prev_next = 0; last_out = '0; prev_idx = '0; prev_out = '0;
    for (int c = 0; c < 40 && rk_valid; c++) begin
      if (have_prev && !prev_next) begin
        check("stall idx hold", rk_idx, prev_idx);
        check("stall key hold", rk_out, prev_out);
      end
      rk_next = (c < 4) ? pat[c] : 1'b1;
      if (rk_next) taken.push_back(int'(rk_idx));
      if (rk_next && rk_idx == 0) last_out = rk_out;
      prev_idx = rk_idx; prev_out = rk_out; prev_next = rk_next; have_prev = 1;
      @(negedge clk);
    end
    rk_next = 0;
    check("t2 key count", taken.size(), 11);
    err = 0;
    foreach (taken[i]) if (taken[i] != 10 - i) err++;
    check("t2 order errors", err, 0);
    check("t2 last literal", last_out, K2);

    // key_valid beats replay_req, then reset mid-SERVE
    dir = 0; key_in = K1; key_valid = 1; replay_req = 1;
    @(negedge clk);
    key_valid = 0; replay_req = 0;
    check("t6 expanding key_ready", key_ready, 0);
    check("t6 expanding rk_valid", rk_valid, 0);
    check("t6 sched_valid cleared", sched_valid, 0);
    wait_done(cyc);
    check("t6 latency", cyc, 10);
    check("t6 idx0 key", rk_out, K1);
    repeat (2) @(negedge clk);
    check("t6 held idx", rk_idx, 0);
    rst = 1;
    @(negedge clk);
    rst = 0;
    check_reset_outputs("rst mid");

    // Abort part-way through expansion
    dir = 0; key_in = K2; key_valid = 1;
    @(negedge clk);
    key_valid = 0;
    repeat (4) @(negedge clk);
    abort = 1;
    @(negedge clk);
    abort = 0;
    check("abort sched_valid", sched_valid, 0);
    check("abort key_ready", key_ready, 1);
    check("abort sched_done", sched_done, 0);
    done_seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (sched_done) done_seen = 1;
    end
    check("abort no done later", done_seen, 0);
    replay_req = 1;
    @(negedge clk);
    replay_req = 0;
    check("abort replay ignored valid", rk_valid, 0);
    check("abort replay ignored ready", key_ready, 1);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
